// File: rtl/result_banner_gen.sv
// result_banner_gen: end-of-game result banner renderer.
// Latches the game result and display mode when the result state is entered,
// advances a blink phase or scroll position on each slow tick, and draws the
// WINNER/LOSER/TIE glyph run onto a flat character-code bus (slot 0 = MSBs).
module result_banner_gen #(
  parameter int N_CHAR       = 16,
  parameter int CHAR_W       = 8,
  parameter int GRAPH_LEN    = 4,
  parameter int HOME_POS     = 4,
  parameter int BLINK_PERIOD = 7,
  parameter int ON_TICKS     = 4,
  parameter logic [CHAR_W-1:0] FONT_NONE = 8'h20,
  parameter logic [CHAR_W-1:0] WIN_BASE  = 8'h80,
  parameter logic [CHAR_W-1:0] LOSE_BASE = 8'h84,
  parameter logic [CHAR_W-1:0] TIE_BASE  = 8'h88
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     tick,
  input  logic                     active,
  input  logic [1:0]               result,
  input  logic [1:0]               mode,
  output logic [N_CHAR*CHAR_W-1:0] data_out,
  output logic                     banner_on,
  output logic                     cycle_done
);

  localparam int POS_W = (N_CHAR > 1) ? $clog2(N_CHAR) : 1;
  localparam int PH_W  = $clog2(BLINK_PERIOD);

  localparam logic [1:0] MODE_BLINK  = 2'd1;
  localparam logic [1:0] MODE_SCROLL = 2'd2;

  logic             act_q;
  logic [1:0]       res_q;
  logic [1:0]       mode_q;
  logic [PH_W-1:0]  phase;
  logic [POS_W-1:0] pos;

  logic             phase_wrap;
  logic             pos_wrap;
  logic             blink_off;
  logic [CHAR_W-1:0] base;

  assign phase_wrap = (phase == PH_W'(BLINK_PERIOD - 1));
  assign pos_wrap   = (pos == POS_W'(N_CHAR - 1));
  // Compare in 32 bits so ON_TICKS == BLINK_PERIOD cannot truncate.
  assign blink_off  = (mode_q == MODE_BLINK) && (32'(phase) >= ON_TICKS);
  assign banner_on  = act_q && !blink_off;

  // Latch result/mode on entry, then advance the animation on each tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q      <= 1'b0;
      res_q      <= 2'd0;
      mode_q     <= 2'd0;
      phase      <= '0;
      pos        <= POS_W'(HOME_POS);
      cycle_done <= 1'b0;
    end else begin
      cycle_done <= 1'b0;
      if (!active) begin
        act_q <= 1'b0;
        phase <= '0;
        pos   <= POS_W'(HOME_POS);
      end else if (!act_q) begin
        // A tick coinciding with the entry edge is deliberately dropped.
        act_q  <= 1'b1;
        res_q  <= result;
        mode_q <= mode;
        phase  <= '0;
        pos    <= POS_W'(HOME_POS);
      end else if (tick) begin
        if (mode_q == MODE_SCROLL) begin
          pos <= pos_wrap ? '0 : pos + 1'b1;
          if (pos_wrap) cycle_done <= 1'b1;
        end else begin
          phase <= phase_wrap ? '0 : phase + 1'b1;
          if (phase_wrap) cycle_done <= 1'b1;
        end
      end
    end
  end

  // Pick the glyph family for the latched result; codes 2 and 3 both mean tie.
  always_comb begin
    case (res_q)
      2'd0:    base = WIN_BASE;
      2'd1:    base = LOSE_BASE;
      default: base = TIE_BASE;
    endcase
  end

  // Draw the glyph run starting at the anchor slot, wrapping past the last slot.
  always_comb begin
    int anchor;
    int off;
    data_out = {N_CHAR{FONT_NONE}};
    anchor   = (mode_q == MODE_SCROLL) ? int'(pos) : HOME_POS;
    off      = 0;
    for (int s = 0; s < N_CHAR; s++) begin
      off = (s + N_CHAR - anchor) % N_CHAR;
      if (banner_on && (off < GRAPH_LEN)) begin
        data_out[(N_CHAR-s)*CHAR_W-1 -: CHAR_W] = base + CHAR_W'(off);
      end
    end
  end

endmodule

// File: doc/result_banner_gen.md
Name: result_banner_gen

Overview:
- Parametrised generator for the end-of-game result screen.
- Renders a GRAPH_LEN-glyph WINNER/LOSER/TIE banner into an N_CHAR-slot character-code bus for the display driver.
- Supports three display modes: static, blinking and circular scrolling.
- Latches the game result on entry to the result state, counts animation phase on a slow tick, and flags each completed animation cycle to the top-level FSM.

Parameters:
- N_CHAR, 16: character slots on the bus.
- CHAR_W, 8: bits per character code.
- GRAPH_LEN, 4: glyphs per banner.
- HOME_POS, 4: slot of glyph 0 in static/blink mode and at scroll start. Slot 0 is the MSB slot.
- BLINK_PERIOD, 7: ticks per blink/static cycle; phase counts 0..BLINK_PERIOD-1.
- ON_TICKS, 4: banner visible while phase < ON_TICKS in blink mode.
- FONT_NONE, 8'h20: blank character code.
- WIN_BASE, 8'h80: code of WINNER glyph 0; glyph k = WIN_BASE+k.
- LOSE_BASE, 8'h84: code of LOSER glyph 0; glyph k = LOSE_BASE+k.
- TIE_BASE, 8'h88: code of TIE glyph 0; glyph k = TIE_BASE+k.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- tick  in  1  one-clk animation enable pulse (1 Hz strobe).
- active  in  1  high while the top FSM is in the result state.
- result  in  2  0=win, 1=lose, 2/3=tie.
- mode  in  2  0=static, 1=blink, 2=scroll, 3=static.
- data_out  out  N_CHAR*CHAR_W  character codes; slot s occupies bits [(N_CHAR-s)*CHAR_W-1 -: CHAR_W].
- banner_on  out  1  high when any glyph is currently drawn.
- cycle_done  out  1  one-clk pulse at the end of each animation cycle.

Behaviour:
- Reset rst_n is asynchronous, active-low; clock clk. All registers are posedge clk.
- Reset values:
  - act_q=0, res_q=0, mode_q=0, phase=0, pos=HOME_POS.
  - data_out = all FONT_NONE, banner_on=0, cycle_done=0.
- Activation (active=1 while act_q=0), on that edge:
  - latch res_q<=result and mode_q<=mode; set phase<=0, pos<=HOME_POS, act_q<=1.
  - Any tick in the same cycle is ignored.
- While act_q=1:
  - result and mode changes are ignored until the next activation.
  - active=0 clears act_q and holds phase/pos at their reset values.
- Tick handling (act_q=1, active=1, tick=1):
  - static/blink: phase <= (phase==BLINK_PERIOD-1) ? 0 : phase+1; cycle_done=1 on the wrap.
  - scroll: pos <= (pos==N_CHAR-1) ? 0 : pos+1; cycle_done=1 on the N_CHAR-1 to 0 wrap; phase is unused.
  - cycle_done is registered and high exactly the clk after the wrapping tick edge.
- Glyph selection: base = WIN_BASE if res_q==0, LOSE_BASE if res_q==1, otherwise TIE_BASE.
- Rendering (combinational from registers; visible one clk after the causing edge):
  - act_q=0: all slots FONT_NONE.
  - static: slots HOME_POS..HOME_POS+GRAPH_LEN-1 = base+0..base+GRAPH_LEN-1; all others FONT_NONE.
  - blink: same as static when phase<ON_TICKS, else all FONT_NONE.
  - scroll: slot (pos+k) mod N_CHAR = base+k for k=0..GRAPH_LEN-1, wrapping circularly across the right edge; all others FONT_NONE.
- banner_on = act_q && !(mode_q==1 && phase>=ON_TICKS).
- Async reset mid-display blanks the bus immediately. After release, the block waits for a fresh activation edge (active must be seen with act_q=0).
- Legal parameters: GRAPH_LEN<=N_CHAR, HOME_POS+GRAPH_LEN<=N_CHAR, 1<=ON_TICKS<=BLINK_PERIOD, BLINK_PERIOD>=2. Other settings are unsupported.

Test Plan:
1. Static win: reset, active=1, result=0, mode=0 → next clk slots 4..7 = 80,81,82,83, others 20. After 7 ticks, exactly one cycle_done pulse.
2. Blink lose: result=1, mode=1, 7 ticks → banner 84..87 on for phases 0-3 and all-20 for phases 4-6. banner_on tracks this; cycle_done pulses on the 7th tick.
3. Scroll tie with wrap: result=3, mode=2, 10 ticks → pos=14, slots 14,15,0,1 = 88,89,8A,8B. After the 12th tick pos=0 and cycle_done pulses.
4. Latch stability: mid-display change result 0→1 and mode 0→2 → output unchanged. Drop active, raise again → lose banner, scroll from pos 4.
5. Simultaneous tick and activation edge → phase=0, pos=4 afterwards, no cycle_done.
6. Async reset mid-scroll at pos=9 → data_out all 20 immediately. After release with active held high, re-activation restarts the banner at pos 4.
